// File: rtl/ascon_core_sequencer.sv
// ascon_core_sequencer
// Control FSM that walks one ascon_core through an AEAD encrypt/decrypt
// (init, associated data, text, final) or a hash (init, message), taking
// 128-bit blocks from the host and returning per-block output and the tag.
// Every core-facing and host-facing output is a flop decoded from the next
// state, so all of them line up exactly with the registered FSM state.

module ascon_core_sequencer #(
   parameter int BLOCK_BYTES = 16,
   parameter int LEN_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [1:0]       sel_type_i,
   input  logic [LEN_W-1:0] ad_len,
   input  logic [LEN_W-1:0] text_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   output logic             out_valid,
   output logic [127:0]     out_data,
   output logic             tag_valid,
   output logic [127:0]     tag_o,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       core_sel_type,
   output logic             core_mode_sel,
   output logic [LEN_W-1:0] core_data_length,
   output logic [LEN_W-1:0] core_data_position,
   output logic [127:0]     core_data_in,
   input  logic [127:0]     core_data_out,
   input  logic [127:0]     core_tag,
   output logic             core_en_init,
   output logic             core_en_ae_am,
   output logic             core_en_encrypt_decrypt,
   output logic             core_en_hash,
   output logic             core_en_final
);

   typedef enum logic [3:0] {
      IDLE, INIT, AD_WAIT, AD_RUN0, AD_RUN1,
      TX_WAIT, TX_RUN0, TX_RUN1, FINAL, DONE
   } state_t;

   localparam logic [1:0]       OP_HASH = 2'd2;
   localparam logic [1:0]       OP_ILL  = 2'd3;
   localparam logic [LEN_W-1:0] BLK_INC = LEN_W'(BLOCK_BYTES);
   localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

   // Number of blocks needed to cover len bytes (a partial block counts).
   function automatic logic [LEN_W-1:0] ceil_blocks(input logic [LEN_W-1:0] len);
      logic [LEN_W-1:0] whole;
      whole = len / BLK_INC;
      if ((len % BLK_INC) != '0) whole = whole + ONE;
      return whole;
   endfunction

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [LEN_W-1:0] ad_len_q, ad_len_d;
   logic [LEN_W-1:0] text_len_q, text_len_d;
   logic [LEN_W-1:0] blk_q, blk_d;
   logic [LEN_W-1:0] pos_q, pos_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [1:0]       sel_q, sel_d;
   logic             mode_q, mode_d;
   logic [127:0]     din_q, din_d;
   logic [127:0]     out_data_q, out_data_d;
   logic [127:0]     tag_q, tag_d;
   logic             out_valid_q, out_valid_d;
   logic             tag_valid_q, tag_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             en_init_q, en_init_d;
   logic             en_ae_q, en_ae_d;
   logic             en_ed_q, en_ed_d;
   logic             en_hash_q, en_hash_d;
   logic             en_final_q, en_final_d;
   logic             accept;

   // Next-state, datapath updates and next-cycle output decode.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      ad_len_d    = ad_len_q;
      text_len_d  = text_len_q;
      blk_d       = blk_q;
      pos_d       = pos_q;
      sel_d       = sel_q;
      mode_d      = mode_q;
      din_d       = din_q;
      out_data_d  = out_data_q;
      tag_d       = tag_q;
      tag_valid_d = tag_valid_q;
      out_valid_d = 1'b0;

      accept = start && (state_q == IDLE) && (op != OP_ILL);
      err_d  = start && !accept;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = INIT;
               op_d        = op;
               sel_d       = sel_type_i;
               mode_d      = op[0];
               ad_len_d    = ad_len;
               text_len_d  = text_len;
               tag_valid_d = 1'b0;
            end
         end
         INIT: begin
            pos_d = '0;
            if (op_q == OP_HASH) begin
               state_d = TX_WAIT;
               blk_d   = (text_len_q == '0) ? ONE : ceil_blocks(text_len_q);
            end else if (ad_len_q != '0) begin
               state_d = AD_WAIT;
               blk_d   = ceil_blocks(ad_len_q);
            end else if (text_len_q != '0) begin
               state_d = TX_WAIT;
               blk_d   = ceil_blocks(text_len_q);
            end else begin
               state_d = FINAL;
            end
         end
         AD_WAIT: begin
            if (in_valid && in_ready_q) begin
               din_d   = in_data;
               state_d = AD_RUN0;
            end
         end
         AD_RUN0: state_d = AD_RUN1;
         AD_RUN1: begin
            pos_d = pos_q + BLK_INC;
            blk_d = blk_q - ONE;
            if (blk_q != ONE) begin
               state_d = AD_WAIT;
            end else if (text_len_q != '0) begin
               state_d = TX_WAIT;
               pos_d   = '0;
               blk_d   = ceil_blocks(text_len_q);
            end else begin
               state_d = FINAL;
            end
         end
         TX_WAIT: begin
            if (in_valid && in_ready_q) begin
               din_d   = in_data;
               state_d = TX_RUN0;
            end
         end
         TX_RUN0: state_d = TX_RUN1;
         TX_RUN1: begin
            out_data_d  = core_data_out;
            out_valid_d = 1'b1;
            pos_d       = pos_q + BLK_INC;
            blk_d       = blk_q - ONE;
            if (blk_q != ONE)           state_d = TX_WAIT;
            else if (op_q == OP_HASH)   state_d = DONE;
            else                        state_d = FINAL;
         end
         FINAL: begin
            tag_d   = core_tag;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == AD_WAIT) || (state_d == TX_WAIT);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      en_init_d  = (state_d == INIT);
      en_ae_d    = (state_d == AD_RUN0) || (state_d == AD_RUN1);
      en_ed_d    = ((state_d == TX_RUN0) || (state_d == TX_RUN1)) && (op_q != OP_HASH);
      en_hash_d  = ((state_d == TX_RUN0) || (state_d == TX_RUN1)) && (op_q == OP_HASH);
      en_final_d = (state_d == FINAL);
      if ((state_d == DONE) && (op_q != OP_HASH)) tag_valid_d = 1'b1;

      // The AD phase reports ad_len; every other state reports text_len.
      // On the accepting cycle the latched copy is not written yet, so the
      // live input is used instead.
      if ((state_d == AD_WAIT) || (state_d == AD_RUN0) || (state_d == AD_RUN1))
         len_d = ad_len_q;
      else
         len_d = text_len_q;
      if (accept) len_d = text_len;
   end

   // State and output registers; reset clears everything and drops enables.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         ad_len_q    <= '0;
         text_len_q  <= '0;
         blk_q       <= '0;
         pos_q       <= '0;
         len_q       <= '0;
         sel_q       <= '0;
         mode_q      <= 1'b0;
         din_q       <= '0;
         out_data_q  <= '0;
         tag_q       <= '0;
         out_valid_q <= 1'b0;
         tag_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         en_init_q   <= 1'b0;
         en_ae_q     <= 1'b0;
         en_ed_q     <= 1'b0;
         en_hash_q   <= 1'b0;
         en_final_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         ad_len_q    <= ad_len_d;
         text_len_q  <= text_len_d;
         blk_q       <= blk_d;
         pos_q       <= pos_d;
         len_q       <= len_d;
         sel_q       <= sel_d;
         mode_q      <= mode_d;
         din_q       <= din_d;
         out_data_q  <= out_data_d;
         tag_q       <= tag_d;
         out_valid_q <= out_valid_d;
         tag_valid_q <= tag_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         en_init_q   <= en_init_d;
         en_ae_q     <= en_ae_d;
         en_ed_q     <= en_ed_d;
         en_hash_q   <= en_hash_d;
         en_final_q  <= en_final_d;
      end
   end

   assign in_ready                = in_ready_q;
   assign out_valid               = out_valid_q;
   assign out_data                = out_data_q;
   assign tag_valid               = tag_valid_q;
   assign tag_o                   = tag_q;
   assign busy                    = busy_q;
   assign done                    = done_q;
   assign err                     = err_q;
   assign core_sel_type           = sel_q;
   assign core_mode_sel           = mode_q;
   assign core_data_length        = len_q;
   assign core_data_position      = pos_q;
   assign core_data_in            = din_q;
   assign core_en_init            = en_init_q;
   assign core_en_ae_am           = en_ae_q;
   assign core_en_encrypt_decrypt = en_ed_q;
   assign core_en_hash            = en_hash_q;
   assign core_en_final           = en_final_q;

endmodule

// File: doc/ascon_core_sequencer.md
Name: ascon_core_sequencer

Overview:
- Control FSM that sequences one ascon_core instance through a full operation: AEAD encrypt or decrypt (init, associated data, text, final), or hash (init, message).
- Accepts 128-bit blocks through a valid/ready handshake.
- Drives the core's one-hot process enables, data length and data position, and respects the core's 2-cycle per-block update.
- Returns per-block output and the final tag to the host.
- Key and nonce are wired to the core directly; this block does not carry them.

Parameters:
- BLOCK_BYTES, 16, bytes consumed per block; position increment.
- LEN_W, 32, width of the length and position fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin an operation; sampled only in IDLE
- op  in  2  0=encrypt, 1=decrypt, 2=hash, 3=illegal
- sel_type_i  in  2  variant select, latched on start
- ad_len  in  LEN_W  associated-data bytes, latched on start
- text_len  in  LEN_W  text or message bytes, latched on start
- in_valid  in  1  host block valid
- in_ready  out  1  sequencer can accept a block
- in_data  in  128  host block
- out_valid  out  1  one-cycle pulse, out_data valid
- out_data  out  128  captured core output
- tag_valid  out  1  tag_o valid
- tag_o  out  128  captured tag
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on rejected start
- core_sel_type  out  2  to core
- core_mode_sel  out  1  to core; 0=encrypt, 1=decrypt
- core_data_length  out  LEN_W  to core
- core_data_position  out  LEN_W  to core
- core_data_in  out  128  to core; registered block
- core_data_out  in  128  from core
- core_tag  in  128  from core
- core_en_init, core_en_ae_am, core_en_encrypt_decrypt, core_en_hash, core_en_final  out  1 each  core enables; at most one high in any cycle

Behaviour:
- Reset values (asynchronous): all outputs 0; state IDLE; counters 0.
- FSM states: IDLE, INIT, AD_WAIT, AD_RUN0, AD_RUN1, TX_WAIT, TX_RUN0, TX_RUN1, FINAL, DONE.
- IDLE:
  - start with op<3: latch op, sel_type_i, ad_len, text_len; go to INIT.
  - start with op==3: err pulse next cycle; stay in IDLE.
- start outside IDLE: ignored, err pulse next cycle.
- busy: 1 in every state except IDLE.
- INIT: core_en_init=1 for exactly one cycle. Next state:
  - TX_WAIT if op==2;
  - else AD_WAIT if ad_len!=0;
  - else TX_WAIT if text_len!=0;
  - else FINAL.
- Block counts:
  - AD blocks = ceil(ad_len/BLOCK_BYTES).
  - Text blocks = ceil(text_len/BLOCK_BYTES).
  - Hash blocks = max(1, ceil(text_len/BLOCK_BYTES)).
- *_WAIT states:
  - in_ready=1.
  - On in_valid&&in_ready: register in_data into core_data_in, go to *_RUN0.
  - No timeout.
- *_RUN0 and *_RUN1: the phase enable is high in both cycles.
  - AD phase: core_en_ae_am.
  - Text phase: core_en_encrypt_decrypt for op 0/1, core_en_hash for op 2.
  - core_data_in is held constant across both cycles.
- At the end of TX_RUN1: capture core_data_out into out_data; out_valid pulses in the following cycle. The AD phase produces no out_valid.
- After each *_RUN1:
  - position += BLOCK_BYTES; block counter decrements.
  - If blocks remain, return to the same *_WAIT.
  - Otherwise the AD phase goes to TX_WAIT if text_len!=0, else FINAL. The text phase goes to FINAL for op 0/1 and to DONE for op 2.
- core_data_position: 0 at the start of each phase; equals the byte offset of the current block.
- core_data_length: ad_len in the AD phase, text_len otherwise.
- core_mode_sel: op[0].
- core_sel_type: latched sel_type_i.
- FINAL: core_en_final=1 for one cycle; core_tag captured into tag_o at the end of that cycle.
- DONE:
  - done=1 for one cycle; then IDLE.
  - tag_valid=1 from DONE until the next accepted start, for op 0/1 only.
  - For op 2, tag_valid stays 0 and the hash result is the last out_data.
- No output backpressure: the host must accept out_valid pulses.
- Reset mid-operation: all enables drop asynchronously; FSM returns to IDLE; captured data and tag cleared.
- Position and length arithmetic is unsigned LEN_W. Wrap of position is not checked; lengths are limited to 2^LEN_W-1.

Test Plan:
- Encrypt, ad_len=20, text_len=16, in_valid held 1, start at cycle 0 -> expected sequence:
  - core_en_init in cycle 1.
  - core_en_ae_am in cycles 3-4 (position 0) and 6-7 (position 16), core_data_length=20.
  - core_en_encrypt_decrypt in cycles 9-10 (position 0).
  - out_valid and core_en_final in cycle 11.
  - done and tag_valid in cycle 12.
- Encrypt, ad_len=0, text_len=0 -> init in cycle 1, final in cycle 2, done in cycle 3; no out_valid.
- Hash, text_len=0 -> exactly one core_en_hash pair; out_valid once; done; tag_valid stays 0; core_en_final never asserted.
- Decrypt, text_len=40, in_valid deasserted 5 cycles before each block -> in_ready held in TX_WAIT; 3 blocks at positions 0, 16, 32; core_mode_sel=1; enables never overlap.
- start with op=3, and start while busy -> err pulse; FSM state and outputs unchanged.
- rst asserted during TX_RUN0 -> all enables 0 immediately; busy=0; next start runs normally from INIT.
